cpu_control_unit: RTL and testbench

- Multi-cycle fetch/decode/sequence controller of the 8-bit softcore, directly upstream of the ALU.
- Fetches 16-bit instructions as two bytes over an 8-bit instruction port and decodes them.
- Drives the ALU operand selects, the one-hot alu_mode, and the register-file/accumulator write enables.
- Owns the PC. Every PC update (PC+2 or PC+offset) goes through the ALU adder.

---
 rtl/cpu_control_unit_pkg.sv | 63 ++++++
 rtl/cpu_control_unit_decoder.sv | 38 +++
 rtl/cpu_control_unit.sv | 123 ++++++++++++
 tb/tb_cpu_control_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_unit_pkg.sv
// rtl/cpu_control_unit_pkg.sv - shared encodings for the softcore control unit
package cpu_control_unit_pkg;

  localparam int ALU_MODE_COUNT = 8;
  localparam int ALU_FLAG_COUNT = 2;

  // One-hot bit positions inside alu_mode
  localparam int ALU_MODE_ADD      = 0;
  localparam int ALU_MODE_SH       = 1;
  localparam int ALU_MODE_NOT      = 2;
  localparam int ALU_MODE_AND      = 3;
  localparam int ALU_MODE_OR       = 4;
  localparam int ALU_MODE_XOR      = 5;
  localparam int ALU_MODE_BYPASS_A = 6;
  localparam int ALU_MODE_BYPASS_B = 7;

  // Bit positions inside alu_flags / flags_q
  localparam int ALU_FLAG_EQ = 0;
  localparam int ALU_FLAG_GT = 1;

  localparam logic [3:0] ISA_OP_NOP  = 4'd0;
  localparam logic [3:0] ISA_OP_ADD  = 4'd1;
  localparam logic [3:0] ISA_OP_ADDI = 4'd2;
  localparam logic [3:0] ISA_OP_SH   = 4'd3;
  localparam logic [3:0] ISA_OP_SHI  = 4'd4;
  localparam logic [3:0] ISA_OP_NOT  = 4'd5;
  localparam logic [3:0] ISA_OP_AND  = 4'd6;
  localparam logic [3:0] ISA_OP_OR   = 4'd7;
  localparam logic [3:0] ISA_OP_XOR  = 4'd8;
  localparam logic [3:0] ISA_OP_MVA  = 4'd9;
  localparam logic [3:0] ISA_OP_MVR  = 4'd10;
  localparam logic [3:0] ISA_OP_BEQ  = 4'd11;
  localparam logic [3:0] ISA_OP_BGT  = 4'd12;
  localparam logic [3:0] ISA_OP_JMP  = 4'd13;
  localparam logic [3:0] ISA_OP_RSVD = 4'd14;
  localparam logic [3:0] ISA_OP_HALT = 4'd15;

  localparam logic [2:0] CU_ST_FETCH0 = 3'd0;
  localparam logic [2:0] CU_ST_FETCH1 = 3'd1;
  localparam logic [2:0] CU_ST_EXEC   = 3'd2;
  localparam logic [2:0] CU_ST_PC_UPD = 3'd3;
  localparam logic [2:0] CU_ST_HALTED = 3'd4;

  localparam logic [1:0] ALU_B_SEL_REG = 2'd0;
  localparam logic [1:0] ALU_B_SEL_IMM = 2'd1;
  localparam logic [1:0] ALU_B_SEL_TWO = 2'd2;
  localparam logic [1:0] ALU_B_SEL_OFF = 2'd3;

  // EXEC-cycle controls produced by the decoder
  typedef struct packed {
    logic [ALU_MODE_COUNT-1:0] alu_mode;
    logic [1:0]                b_sel;
    logic                      acc_we;
    logic                      rf_we;
    logic                      is_branch;
    logic                      is_halt;
  } cu_ctrl_t;

  function automatic logic [ALU_MODE_COUNT-1:0] mode_onehot(input int idx);
    return ALU_MODE_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/cpu_control_unit_decoder.sv
// rtl/cpu_control_unit_decoder.sv - combinational opcode decoder
module cu_decoder
  import cpu_control_unit_pkg::*;
(
  input  logic [3:0] op,
  output cu_ctrl_t   ctrl
);

  // Map opcode to ALU mode, operand-B select and write/branch/halt flags
  always_comb begin
    ctrl = '0;
    case (op)
      ISA_OP_ADD:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_ADD); ctrl.acc_we = 1'b1; end
      ISA_OP_ADDI: begin
        ctrl.alu_mode = mode_onehot(ALU_MODE_ADD);
        ctrl.b_sel    = ALU_B_SEL_IMM;
        ctrl.acc_we   = 1'b1;
      end
      ISA_OP_SH:   begin ctrl.alu_mode = mode_onehot(ALU_MODE_SH); ctrl.acc_we = 1'b1; end
      ISA_OP_SHI:  begin
        ctrl.alu_mode = mode_onehot(ALU_MODE_SH);
        ctrl.b_sel    = ALU_B_SEL_IMM;
        ctrl.acc_we   = 1'b1;
      end
      ISA_OP_NOT:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_NOT); ctrl.acc_we = 1'b1; end
      ISA_OP_AND:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_AND); ctrl.acc_we = 1'b1; end
      ISA_OP_OR:   begin ctrl.alu_mode = mode_onehot(ALU_MODE_OR);  ctrl.acc_we = 1'b1; end
      ISA_OP_XOR:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_XOR); ctrl.acc_we = 1'b1; end
      ISA_OP_MVA:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_BYPASS_B); ctrl.acc_we = 1'b1; end
      ISA_OP_MVR:  begin ctrl.alu_mode = mode_onehot(ALU_MODE_BYPASS_A); ctrl.rf_we = 1'b1; end
      ISA_OP_BEQ:  ctrl.is_branch = 1'b1;
      ISA_OP_BGT:  ctrl.is_branch = 1'b1;
      ISA_OP_HALT: ctrl.is_halt = 1'b1;
      default:     ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/sequence controller of the 8-bit softcore
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int                   BIT_COUNT = 8,
  parameter logic [BIT_COUNT-1:0] RESET_PC  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req,
  output logic [BIT_COUNT-1:0]      imem_addr,
  input  logic [7:0]                imem_rdata,
  input  logic                      imem_valid,
  output logic                      alu_a_sel,
  output logic [1:0]                alu_b_sel,
  output logic [BIT_COUNT-1:0]      alu_imm,
  output logic [ALU_MODE_COUNT-1:0] alu_mode,
  input  logic [BIT_COUNT-1:0]      alu_c,
  input  logic [ALU_FLAG_COUNT-1:0] alu_flags,
  output logic [2:0]                rf_raddr,
  output logic [2:0]                rf_waddr,
  output logic                      rf_we,
  output logic                      acc_we,
  output logic [BIT_COUNT-1:0]      pc,
  output logic [ALU_FLAG_COUNT-1:0] flags_q,
  output logic                      halted
);

  logic [2:0]  state;
  logic [15:0] insn;
  logic        take_q;
  logic        take_next;
  cu_ctrl_t    ctrl;
  logic [3:0]  op;
  logic [2:0]  r;
  logic        unused_insn_bit;

  assign op              = insn[15:12];
  assign r               = insn[11:9];
  assign unused_insn_bit = insn[8];
  assign rf_raddr        = r;
  assign rf_waddr        = r;

  cu_decoder u_decoder (
    .op   (op),
    .ctrl (ctrl)
  );

  // Branch decision taken from the live flags during EXEC, used one cycle later in PC_UPD
  assign take_next = ((op == ISA_OP_BEQ) && alu_flags[ALU_FLAG_EQ]) ||
                     ((op == ISA_OP_BGT) && alu_flags[ALU_FLAG_GT]) ||
                      (op == ISA_OP_JMP);

  // Offset operand is sign-extended; the ALU-immediate form is zero-extended
  assign alu_imm = (alu_b_sel == ALU_B_SEL_OFF) ? BIT_COUNT'($signed(insn[7:0]))
                                                : BIT_COUNT'(insn[3:0]);

  // Per-state datapath controls; fetch request is masked while reset is held
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    alu_a_sel = 1'b0;
    alu_b_sel = ALU_B_SEL_REG;
    alu_mode  = '0;
    acc_we    = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (state)
      CU_ST_FETCH0: imem_req = rst_n;
      CU_ST_FETCH1: begin
        imem_req  = rst_n;
        imem_addr = pc + BIT_COUNT'(1);
      end
      CU_ST_EXEC: begin
        alu_b_sel = ctrl.b_sel;
        alu_mode  = ctrl.alu_mode;
        acc_we    = ctrl.acc_we;
        rf_we     = ctrl.rf_we && (r != 3'd7);
      end
      CU_ST_PC_UPD: begin
        alu_a_sel = 1'b1;
        alu_mode  = mode_onehot(ALU_MODE_ADD);
        alu_b_sel = take_q ? ALU_B_SEL_OFF : ALU_B_SEL_TWO;
      end
      CU_ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // Sequencer: two byte fetches, one execute cycle, one PC update through the ALU adder
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CU_ST_FETCH0;
      pc      <= RESET_PC;
      insn    <= '0;
      flags_q <= '0;
      take_q  <= 1'b0;
    end else begin
      case (state)
        CU_ST_FETCH0: if (imem_valid) begin
          insn[15:8] <= imem_rdata;
          state      <= CU_ST_FETCH1;
        end
        CU_ST_FETCH1: if (imem_valid) begin
          insn[7:0] <= imem_rdata;
          state     <= CU_ST_EXEC;
        end
        CU_ST_EXEC: begin
          if (ctrl.is_branch) flags_q <= alu_flags;
          take_q <= take_next;
          state  <= ctrl.is_halt ? CU_ST_HALTED : CU_ST_PC_UPD;
        end
        CU_ST_PC_UPD: begin
          pc    <= alu_c;
          state <= CU_ST_FETCH0;
        end
        CU_ST_HALTED: state <= CU_ST_HALTED;
        default:      state <= CU_ST_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - scoreboard bench for cpu_control_unit
module tb_cpu_control_unit;
  import cpu_control_unit_pkg::*;

  typedef struct {
    bit         is_acc;
    logic [2:0] waddr;
    int         mode;
    logic [1:0] bsel;
    logic [7:0] imm;
  } wr_t;

  typedef struct {
    logic [7:0] old_pc;
    bit         take;
    logic [7:0] off;
    logic [7:0] new_pc;
    logic [1:0] flags;
  } pu_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [7:0] alu_imm;
  logic [7:0] alu_mode;
  logic [7:0] alu_c;
  logic [1:0] alu_flags;
  logic [2:0] rf_raddr;
  logic [2:0] rf_waddr;
  logic       rf_we;
  logic       acc_we;
  logic [7:0] pc;
  logic [1:0] flags_q;
  logic       halted;

  logic [7:0] mem [256];
  logic [7:0] init_acc;
  logic [7:0] init_regs [8];
  logic [7:0] env_acc;
  logic [7:0] env_regs [8];
  logic       dir_mode = 1'b1;
  logic       dir_ready = 1'b1;
  logic       rnd_ready = 1'b1;

  wr_t        write_q [$];
  pu_t        pc_q [$];
  bit         exp_halt;
  bit         pend = 1'b0;
  logic [7:0] pend_pc;
  int         total = 0;
  int         bad = 0;

  cpu_control_unit #(.BIT_COUNT(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_imm(alu_imm), .alu_mode(alu_mode), .alu_c(alu_c),
    .alu_flags(alu_flags), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .acc_we(acc_we), .pc(pc), .flags_q(flags_q), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory: valid may be asserted in any state, the DUT must ignore it outside fetch
  assign imem_valid = dir_mode ? dir_ready : rnd_ready;
  assign imem_rdata = mem[imem_addr];
  always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  // ALU and register file environment driven by the DUT's selects and strobes
  always_comb begin
    logic [7:0] a, b, regb;
    regb = (rf_raddr == 3'd7) ? 8'h00 : env_regs[rf_raddr];
    a = alu_a_sel ? pc : env_acc;
    case (alu_b_sel)
      2'd0:    b = regb;
      2'd2:    b = 8'd2;
      default: b = alu_imm;
    endcase
    alu_c = 8'h00;
    if (alu_mode[ALU_MODE_ADD])      alu_c = a + b;
    if (alu_mode[ALU_MODE_SH])       alu_c = a << b[2:0];
    if (alu_mode[ALU_MODE_NOT])      alu_c = ~a;
    if (alu_mode[ALU_MODE_AND])      alu_c = a & b;
    if (alu_mode[ALU_MODE_OR])       alu_c = a | b;
    if (alu_mode[ALU_MODE_XOR])      alu_c = a ^ b;
    if (alu_mode[ALU_MODE_BYPASS_A]) alu_c = a;
    if (alu_mode[ALU_MODE_BYPASS_B]) alu_c = b;
    alu_flags = 2'b00;
    alu_flags[ALU_FLAG_EQ] = (env_acc == regb);
    alu_flags[ALU_FLAG_GT] = (env_acc > regb);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      env_acc  <= init_acc;
      env_regs <= init_regs;
    end else begin
      if (acc_we) env_acc <= alu_c;
      if (rf_we)  env_regs[rf_waddr] <= alu_c;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: executes the program and queues expected events
  task automatic model_run(input int n);
    logic [7:0] mpc, acc, rb, res;
    logic [7:0] regs [8];
    logic [1:0] mflags;
    logic [15:0] insn;
    logic [3:0] op;
    logic [2:0] r;
    bit take, wr;
    wr_t w;
    pu_t p;
    mpc = 8'h00;
    acc = init_acc;
    regs = init_regs;
    mflags = 2'b00;
    exp_halt = 1'b0;
    for (int k = 0; k < n; k++) begin
      insn = {mem[mpc], mem[mpc + 8'd1]};
      op = insn[15:12];
      r = insn[11:9];
      rb = (r == 3'd7) ? 8'h00 : regs[r];
      take = 1'b0;
      wr = 1'b1;
      w.is_acc = 1'b1; w.waddr = r; w.bsel = 2'd0; w.imm = {4'h0, insn[3:0]}; w.mode = 0;
      res = 8'h00;
      case (op)
        4'd1:  begin w.mode = ALU_MODE_ADD; res = acc + rb; end
        4'd2:  begin w.mode = ALU_MODE_ADD; w.bsel = 2'd1; res = acc + w.imm; end
        4'd3:  begin w.mode = ALU_MODE_SH; res = acc << rb[2:0]; end
        4'd4:  begin w.mode = ALU_MODE_SH; w.bsel = 2'd1; res = acc << w.imm[2:0]; end
        4'd5:  begin w.mode = ALU_MODE_NOT; res = ~acc; end
        4'd6:  begin w.mode = ALU_MODE_AND; res = acc & rb; end
        4'd7:  begin w.mode = ALU_MODE_OR; res = acc | rb; end
        4'd8:  begin w.mode = ALU_MODE_XOR; res = acc ^ rb; end
        4'd9:  begin w.mode = ALU_MODE_BYPASS_B; res = rb; end
        4'd10: begin w.mode = ALU_MODE_BYPASS_A; w.is_acc = 1'b0; wr = (r != 3'd7); end
        4'd11: begin wr = 1'b0; mflags = {acc > rb, acc == rb}; take = (acc == rb); end
        4'd12: begin wr = 1'b0; mflags = {acc > rb, acc == rb}; take = (acc > rb); end
        4'd13: begin wr = 1'b0; take = 1'b1; end
        4'd15: begin exp_halt = 1'b1; break; end
        default: wr = 1'b0;
      endcase
      if (wr) begin
        write_q.push_back(w);
        if (w.is_acc) acc = res;
        else regs[r] = acc;
      end
      p.old_pc = mpc;
      p.take = take;
      p.off = insn[7:0];
      mpc = take ? mpc + insn[7:0] : mpc + 8'd2;
      p.new_pc = mpc;
      p.flags = mflags;
      pc_q.push_back(p);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT strobes a write or updates the PC
  always @(negedge clk) begin
    wr_t w;
    pu_t p;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("pc_next", {imem_req, pc, imem_addr}, {1'b1, pend_pc, pend_pc});
        pend = 1'b0;
      end
      if (acc_we || rf_we) begin
        if (write_q.size() == 0) chk("unexpected_write", {acc_we, rf_we, rf_waddr}, 0);
        else begin
          w = write_q.pop_front();
          chk("write",
              {8'h00, acc_we, rf_we, (w.is_acc ? 3'd0 : rf_waddr), alu_mode, alu_a_sel, alu_b_sel,
               (w.bsel == 2'd1 ? alu_imm : 8'h00)},
              {8'h00, w.is_acc, !w.is_acc, (w.is_acc ? 3'd0 : w.waddr), 8'(8'd1 << w.mode), 1'b0,
               w.bsel, (w.bsel == 2'd1 ? w.imm : 8'h00)});
        end
      end
      if (alu_a_sel && (alu_mode != 8'h00)) begin
        if (pc_q.size() == 0) chk("unexpected_pc_upd", {pc, alu_b_sel}, 0);
        else begin
          p = pc_q.pop_front();
          chk("pc_upd",
              {pc, alu_b_sel, (p.take ? alu_imm : 8'h00), flags_q, alu_mode, acc_we, rf_we},
              {p.old_pc, (p.take ? 2'd3 : 2'd2), (p.take ? p.off : 8'h00), p.flags, 8'h01, 2'b00});
          pend = 1'b1;
          pend_pc = p.new_pc;
        end
      end
    end
  end

  task automatic start_prog(input int n, input bit rnd);
    rst_n = 1'b0;
    dir_mode = !rnd;
    dir_ready = 1'b1;
    write_q.delete();
    pc_q.delete();
    model_run(n);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int cyc;
    bit seen;
    cyc = 0;
    while ((write_q.size() != 0 || pc_q.size() != 0 || pend) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_in_time", (cyc < 3000), 1);
    if (exp_halt) begin
      cyc = 0;
      while (!halted && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      chk("halted", halted, 1);
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (imem_req || acc_we || rf_we || !halted) seen = 1'b1;
      end
      chk("halt_quiet", seen, 0);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    init_acc = 8'h00;
    for (int i = 0; i < 8; i++) init_regs[i] = 8'h00;
  endtask

  task automatic put16(input logic [7:0] addr, input logic [15:0] v);
    mem[addr] = v[15:8];
    mem[addr + 8'd1] = v[7:0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {pc, halted, flags_q, imem_req, alu_mode, acc_we, rf_we},
        {8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0});

    // ADDI r0,3 with zero-wait memory: 4-cycle cadence
    put16(8'h00, 16'h2003);
    start_prog(1, 1'b0);
    #1 chk("c1_fetch0", {imem_req, imem_addr}, {1'b1, 8'h00});
    @(negedge clk) chk("c2_fetch1", {imem_req, imem_addr}, {1'b1, 8'h01});
    @(negedge clk) chk("c3_exec", {acc_we, alu_mode, alu_b_sel, alu_imm}, {1'b1, 8'h01, 2'd1, 8'h03});
    @(negedge clk) chk("c4_pcupd", {alu_a_sel, pc}, {1'b1, 8'h00});
    @(negedge clk) chk("c5_pc", pc, 8'h02);
    drain();

    // FETCH1 stall for five cycles
    start_prog(1, 1'b0);
    #1;
    @(negedge clk);
    dir_ready = 1'b0;
    begin
      bit ok;
      ok = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (!(imem_req && imem_addr == 8'h01 && !acc_we && !rf_we && alu_mode == 8'h00)) ok = 1'b0;
      end
      chk("fetch1_hold", ok, 1);
    end
    dir_ready = 1'b1;
    drain();

    // BEQ taken (EQ=1) and not taken (EQ=0) at pc 0x10 with offset -4
    put16(8'h00, 16'hD010);
    put16(8'h10, 16'hB2FC);
    init_acc = 8'h05;
    init_regs[1] = 8'h05;
    start_prog(2, 1'b0);
    drain();
    chk("beq_taken_pc", pc, 8'h0C);
    init_regs[1] = 8'h06;
    start_prog(2, 1'b0);
    drain();
    chk("beq_not_taken_pc", pc, 8'h12);

    // PC wrap from 0xFE
    put16(8'h00, 16'hD0FE);
    put16(8'hFE, 16'h0000);
    start_prog(2, 1'b0);
    drain();
    chk("wrap_pc", pc, 8'h00);

    // HALT, then a single-cycle reset restarts fetch
    clear_mem();
    put16(8'h00, 16'hF000);
    start_prog(1, 1'b0);
    drain();
    rst_n = 1'b0;
    @(negedge clk);
    chk("halt_reset", {pc, halted}, {8'h00, 1'b0});
    rst_n = 1'b1;
    #1 chk("restart_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
    exp_halt = 1'b1;
    write_q.delete();
    pc_q.delete();
    drain();

    // Reset during FETCH1 with valid high discards the partial instruction
    clear_mem();
    put16(8'h00, 16'h2003);
    start_prog(1, 1'b0);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", {acc_we, rf_we, imem_req, pc}, {1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    #1 chk("mid_reset_fetch0", {imem_req, imem_addr}, {1'b1, 8'h00});
    drain();

    // Random programs, random register state, random memory latency
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      init_acc = 8'($urandom);
      for (int i = 0; i < 8; i++) init_regs[i] = 8'($urandom);
      start_prog(24, 1'b1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
